// File: rtl/eeg_pkg.sv
// eeg_pkg: shared widths, sample type and controller states for the EEG window-mean block
package eeg_pkg;
   localparam int DATA_WIDTH = 18;
   localparam int ADDR_WIDTH = 8;
   localparam int SUM_W = DATA_WIDTH + ADDR_WIDTH;
   typedef logic signed [DATA_WIDTH-1:0] sample_t;
   typedef enum logic [2:0] {COLLECT, DIVIDE, REPLAY, FINISH, WAIT_STD} state_t;
endpackage

// File: rtl/sample_buffer.sv
// sample_buffer: simple dual-port RAM, one write port and one registered read port
// clk, reset_n            : clock, async active-low reset (clears only the read register)
// wr_en, wr_addr, wr_data : write port
// rd_en, rd_addr, rd_data : read port, data valid the cycle after rd_en and held until the next read
module sample_buffer #(
   parameter int DW = 18,
   parameter int AW = 8
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output logic [DW-1:0] rd_data
);
   logic [DW-1:0] mem [2**AW];
   always_ff @(posedge clk)
      if (wr_en) mem[wr_addr] <= wr_data;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) rd_data <= '0;
      else if (rd_en) rd_data <= mem[rd_addr];
endmodule

// File: rtl/eeg_window_mean.sv
// eeg_window_mean: buffers one window of EEG samples, computes their mean and replays them to std_calc
// clk, reset_n                      : clock, async active-low reset
// sample_valid, eeg_in, window_end  : sample stream and window-close pulse
// complete_sqrt                     : std_calc done pulse, releases the next window
// in_ready                          : high while collecting
// eeg, start                        : replayed sample and its 1-cycle strobe
// mean, count                       : result of the last completed window
// complete_acc, window_err          : end-of-replay pulse, rejected-window pulse
// overflow                          : sticky, a sample was dropped on a full buffer
module eeg_window_mean
   import eeg_pkg::*;
#(
   parameter int DATA_WIDTH = 18,
   parameter int ADDR_WIDTH = 8,
   parameter int SAMPLE_SPACING = 8
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         sample_valid,
   input  logic signed [DATA_WIDTH-1:0] eeg_in,
   input  logic                         window_end,
   input  logic                         complete_sqrt,
   output logic                         in_ready,
   output logic signed [DATA_WIDTH-1:0] eeg,
   output logic signed [DATA_WIDTH-1:0] mean,
   output logic [ADDR_WIDTH-1:0]        count,
   output logic                         start,
   output logic                         complete_acc,
   output logic                         window_err,
   output logic                         overflow
);
   localparam int SW = DATA_WIDTH + ADDR_WIDTH;
   localparam int CW = $clog2(SW + 2);
   localparam int SPW = $clog2(SAMPLE_SPACING);
   state_t state, state_nxt;
   logic [ADDR_WIDTH-1:0] ptr, n, idx, rd_addr, r;
   logic signed [SW-1:0] sum;
   logic [SW-1:0] q;
   logic [CW-1:0] k;
   logic [SPW-1:0] sp;
   logic [ADDR_WIDTH:0] n_end, shifted, diff;
   logic full, accept, rd_en, div_done, last_gap, ge, close_ok;
   assign full = &ptr;
   assign accept = state == COLLECT && sample_valid && !full;
   // count as it will be once a sample arriving with window_end is included
   assign n_end = {1'b0, ptr} + (ADDR_WIDTH+1)'(accept);
   assign close_ok = n_end >= (ADDR_WIDTH+1)'(2);
   // k=0 loads |sum|, k=1..SW shift one quotient bit each, k=SW+1 writes mean and reads sample 0
   assign div_done = state == DIVIDE && k == CW'(SW + 1);
   assign last_gap = state == REPLAY && sp == SPW'(SAMPLE_SPACING - 1);
   assign rd_en = div_done || (last_gap && idx != n);
   assign rd_addr = div_done ? '0 : idx;
   assign shifted = {r, q[SW-1]};
   assign ge = shifted >= {1'b0, n};
   assign diff = shifted - {1'b0, n};
   assign in_ready = state == COLLECT;
   assign complete_acc = state == FINISH;
   sample_buffer #(.DW(DATA_WIDTH), .AW(ADDR_WIDTH)) u_buf (
      .clk(clk),
      .reset_n(reset_n),
      .wr_en(accept),
      .wr_addr(ptr),
      .wr_data(eeg_in),
      .rd_en(rd_en),
      .rd_addr(rd_addr),
      .rd_data(eeg)
   );
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) state <= COLLECT;
      else state <= state_nxt;
   always_comb begin
      state_nxt = state;
      case (state)
         COLLECT:  if (window_end && close_ok) state_nxt = DIVIDE;
         DIVIDE:   if (div_done) state_nxt = REPLAY;
         REPLAY:   if (last_gap && idx == n) state_nxt = FINISH;
         FINISH:   state_nxt = WAIT_STD;
         WAIT_STD: if (complete_sqrt) state_nxt = COLLECT;
         default:  state_nxt = COLLECT;
      endcase
   end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         ptr <= '0;
         sum <= '0;
         n <= '0;
         idx <= '0;
         r <= '0;
         q <= '0;
         k <= '0;
         sp <= '0;
         mean <= '0;
         count <= '0;
         start <= 1'b0;
         window_err <= 1'b0;
         overflow <= 1'b0;
      end else begin
         start <= rd_en;
         window_err <= state == COLLECT && window_end && !close_ok;
         if (accept) begin
            ptr <= ptr + ADDR_WIDTH'(1);
            sum <= sum + SW'(eeg_in);
            if (ptr == '0) overflow <= 1'b0;
         end else if (state == COLLECT && sample_valid) overflow <= 1'b1;
         if (state == COLLECT && window_end) begin
            if (close_ok) n <= ADDR_WIDTH'(n_end);
            else begin
               ptr <= '0;
               sum <= '0;
            end
         end
         if (state == WAIT_STD && complete_sqrt) begin
            ptr <= '0;
            sum <= '0;
         end
         if (state == DIVIDE) begin
            k <= div_done ? '0 : k + CW'(1);
            if (k == '0) begin
               q <= $unsigned(sum[SW-1] ? -sum : sum);
               r <= '0;
            end else if (!div_done) begin
               q <= {q[SW-2:0], ge};
               r <= ge ? ADDR_WIDTH'(diff) : ADDR_WIDTH'(shifted);
            end else begin
               mean <= sum[SW-1] ? -q[DATA_WIDTH-1:0] : q[DATA_WIDTH-1:0];
               count <= n;
            end
         end
         if (div_done) begin
            idx <= ADDR_WIDTH'(1);
            sp <= '0;
         end else if (state == REPLAY) begin
            sp <= last_gap ? '0 : sp + SPW'(1);
            if (rd_en) idx <= idx + ADDR_WIDTH'(1);
         end
      end
endmodule

// File: doc/eeg_window_mean.md
Name: eeg_window_mean

Overview:
- Upstream front end of the feature chain, directly feeding std_calc.
- Collects one window of EEG samples into an internal buffer while accumulating their signed sum.
- At window end it computes the truncated mean with a serial divider, then replays the buffered samples one at a time to std_calc as start-strobed eeg values.
- It holds mean/count stable throughout, pulses complete_acc, and waits for complete_sqrt before accepting the next window.

Parameters:
- DATA_WIDTH, 18, sample/mean width, signed Q1.5.12 (sign, 5 integer bits, 12 fraction bits).
- ADDR_WIDTH, 8, buffer address and count width; max window = 2^ADDR_WIDTH-1 samples (255).
- SAMPLE_SPACING, 8, cycles from one replay start pulse to the next (minimum 2).

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset; asynchronous, active-low; all state cleared on assertion
- sample_valid  in  1  eeg_in valid this cycle
- eeg_in  in  DATA_WIDTH  incoming sample, Q1.5.12 two's complement
- window_end  in  1  1-cycle pulse closing the current window
- complete_sqrt  in  1  std_calc done pulse; releases WAIT_STD
- in_ready  out  1  high only in COLLECT
- eeg  out  DATA_WIDTH  replayed sample to std_calc
- mean  out  DATA_WIDTH  window mean, Q1.5.12
- count  out  ADDR_WIDTH  number of samples in window
- start  out  1  1-cycle strobe, eeg valid
- complete_acc  out  1  1-cycle pulse after last replay
- window_err  out  1  1-cycle pulse, window rejected (count<2)
- overflow  out  1  sticky, sample dropped because buffer full

Behaviour:
- Reset values:
  - in_ready=1, all other outputs 0.
  - State COLLECT, write pointer 0, sum 0.
  - Reset may arrive in any state; it aborts the window with no completion pulse.
- Arithmetic:
  - SUM_W = DATA_WIDTH+ADDR_WIDTH (26), signed.
  - Each accepted sample is sign-extended and added; the sum cannot overflow by construction.
- COLLECT:
  - When sample_valid=1 and ptr<255: write eeg_in to buffer[ptr], ptr++, sum += eeg_in.
  - When ptr=255 and sample_valid=1: drop the sample and set overflow=1.
  - overflow clears on the first accepted sample of the next window.
  - If window_end and sample_valid arrive in the same cycle, the sample is included.
  - On window_end with resulting count>=2: latch count=ptr, go to DIVIDE, in_ready=0 from the next cycle.
  - On window_end with count<2: pulse window_err the next cycle, clear ptr and sum, stay in COLLECT.
- DIVIDE:
  - Restoring divider on |sum| / count, SUM_W iterations, 1 bit per cycle.
  - Quotient truncated toward zero, then negated if sum<0.
  - Low DATA_WIDTH bits go to mean; the result always fits because |mean| <= max |sample|.
  - mean and count update exactly once and stay stable until the next window's DIVIDE completes.
  - Duration: SUM_W+2 cycles from the cycle after window_end to the first start pulse.
- REPLAY:
  - For i=0..count-1: eeg=buffer[i], with start=1 for 1 cycle in the same cycle eeg first shows the value.
  - eeg is held until the next sample is presented.
  - Consecutive start pulses are exactly SAMPLE_SPACING cycles apart.
- FINISH:
  - SAMPLE_SPACING cycles after the last start, complete_acc=1 for exactly 1 cycle.
  - Go to WAIT_STD.
- WAIT_STD:
  - On complete_sqrt=1: clear ptr and sum, return to COLLECT (in_ready=1 the next cycle).
  - complete_sqrt outside WAIT_STD is ignored.
- Buffer reads are synchronous, 1-cycle latency; the read for sample i is issued one cycle before its start pulse.

Decomposition:
- Package eeg_pkg holds:
  - DATA_WIDTH, ADDR_WIDTH and SUM_W constants;
  - typedef sample_t = logic signed [DATA_WIDTH-1:0];
  - state enum {COLLECT, DIVIDE, REPLAY, FINISH, WAIT_STD}.
- Sub-module sample_buffer: simple dual-port RAM with one write and one synchronous-read port, depth 2^ADDR_WIDTH.
- The divider stays inline as a counter plus shift registers.

Test Plan:
- Samples 0x00800 (0.5), 0x02000 (2.0), 0x00400 (0.25), 0x08800 (8.5), then window_end:
  - mean=0x02D00 (2.8125), count=4;
  - 4 start pulses carry eeg in input order, spaced 8 cycles apart;
  - complete_acc pulses once 8 cycles after the 4th start;
  - in_ready returns 1 only after complete_sqrt.
- Samples 0x3F000 (-1.0), 0x3E000 (-2.0): mean=0x3E800 (-1.5), count=2.
- Truncation toward zero:
  - samples 0x00001, 0x00000 give mean=0x00000;
  - samples 0x3FFFF, 0x00000 give mean=0x00000, not 0x3FFFF.
- Boundary cases:
  - 300 samples then window_end: count=255, overflow=1, 255 start pulses;
  - window_end with sample_valid in the same cycle counts that sample.
- 1 sample then window_end: window_err pulses 1 cycle, no start or complete_acc, in_ready stays 1, the next window works normally.
- reset_n low mid-REPLAY: all outputs return to reset values immediately, no complete_acc, and a fresh window afterwards gives correct mean and count.
